alu_exec_unit: RTL

Multi-cycle execute stage of the Filter-GPU datapath, directly downstream of the ALU decoder: it consumes `ALUControl[2:0]` and `SrcA` together with two operands and produces a registered result plus NZCV flags. ADD, SUB and MOV complete in one cycle. MUL and the per-pixel CONV (4-lane byte dot product) are iterative. While a multi-cycle operation runs, the block drops `in_ready`, which the pipeline uses as its stall signal.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_seq_mul.sv | 84 ++++++++
 rtl/alu_exec_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the Filter-GPU execute stage.
// Holds the decoder operation codes, the execute FSM state type and the
// bit positions of the {N,Z,C,V} flags inside the 4-bit flags word.
package alu_pkg;

  // Operation codes as produced by the ALU decoder. 001, 010 and 110 are
  // reserved and are deliberately absent from the enum.
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b011,
    ALU_MUL  = 3'b100,
    ALU_CONV = 3'b101,
    ALU_NOP  = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CONV = 2'd2
  } exec_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   flush_i    synchronous cancel of a multiplication in progress
//   start_i    latch a_i/b_i and begin WIDTH iterations
//   a_i, b_i   operands (only sampled when start_i is high)
//   done_o     high during the last iteration; product_o is final then
//   product_o  low WIDTH bits of a*b, valid while done_o is high
module alu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] addend;

  // The product is exposed combinationally so the last iteration's partial
  // product is already folded in on the done cycle; this saves one cycle of
  // latency compared with waiting for the accumulator to update.
  always_comb begin
    addend    = mplier_q[0] ? mcand_q : '0;
    product_o = acc_q + addend;
    done_o    = busy_q && (cnt_q == '0);

    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;

    if (flush_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = CW'(WIDTH - 1);
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
    end else if (busy_q) begin
      acc_d    = product_o;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Iteration state registers; reset clears everything so an aborted
  // multiplication leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute stage: ADD/SUB/MOV in one cycle, MUL via the
// iterative multiplier, CONV as a one-lane-per-cycle byte dot product.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   in_valid/in_ready   operation handshake; in_ready low doubles as stall
//   ALUControl, SrcA    decoder operation code and "force A to zero"
//   op_a, op_b          operands, latched at acceptance
//   flush               synchronous cancel of any in-flight operation
//   out_valid           one-cycle pulse qualifying result/flags
//   result, flags       registered result and {N,Z,C,V}
//   illegal_op          one-cycle pulse after accepting a reserved code
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic             SrcA,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal_op
);

  // Each lane product is below 2^16, so LANES of them fit in 16+log2(LANES).
  localparam int ACC_W  = 16 + $clog2(LANES);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  exec_state_t       state_q, state_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [3:0]        flags_q, flags_d;
  logic              outValid_q, outValid_d;
  logic              illegal_q, illegal_d;
  logic [WIDTH-1:0]  convA_q, convA_d;
  logic [WIDTH-1:0]  convB_q, convB_d;
  logic [ACC_W-1:0]  convAcc_q, convAcc_d;
  logic [LANE_W-1:0] lane_q, lane_d;

  logic              accept;
  logic [WIDTH-1:0]  effA;
  logic [WIDTH:0]    addSum;
  logic [WIDTH:0]    subDiff;
  logic [15:0]       laneProd;
  logic [ACC_W-1:0]  convSum;
  logic              mulStart;
  logic              mulDone;
  logic [WIDTH-1:0]  mulProduct;
  logic              wrEn;
  logic [WIDTH-1:0]  wrRes;
  logic              wrC;
  logic              wrV;

  assign in_ready = (state_q == IDLE) && !flush;
  assign accept   = in_valid && in_ready;
  assign effA     = SrcA ? '0 : op_a;

  // Subtraction is A + ~B + 1 so the top bit is the ARM-style NOT-borrow.
  assign addSum  = {1'b0, effA} + {1'b0, op_b};
  assign subDiff = {1'b0, effA} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};

  // CONV operands shift right one byte per lane so lane i is always at [7:0].
  assign laneProd = {8'd0, convA_q[7:0]} * {8'd0, convB_q[7:0]};
  assign convSum  = convAcc_q + ACC_W'(laneProd);

  assign mulStart = accept && (ALUControl == ALU_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) uMul (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush),
    .start_i   (mulStart),
    .a_i       (effA),
    .b_i       (op_b),
    .done_o    (mulDone),
    .product_o (mulProduct)
  );

  // Next-state logic. Flush wins over everything, including the completing
  // iteration, so a flushed op never produces out_valid. Every result write
  // funnels through wrEn so N/Z are derived in one place.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    flags_d    = flags_q;
    outValid_d = 1'b0;
    illegal_d  = 1'b0;
    convA_d    = convA_q;
    convB_d    = convB_q;
    convAcc_d  = convAcc_q;
    lane_d     = lane_q;
    wrEn       = 1'b0;
    wrRes      = '0;
    wrC        = 1'b0;
    wrV        = 1'b0;

    if (flush) begin
      state_d = IDLE;
      lane_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (ALUControl)
              ALU_ADD: begin
                wrEn  = 1'b1;
                wrRes = addSum[WIDTH-1:0];
                wrC   = addSum[WIDTH];
                wrV   = (effA[WIDTH-1] == op_b[WIDTH-1]) &&
                        (addSum[WIDTH-1] != effA[WIDTH-1]);
              end
              ALU_SUB: begin
                wrEn  = 1'b1;
                wrRes = subDiff[WIDTH-1:0];
                wrC   = subDiff[WIDTH];
                wrV   = (effA[WIDTH-1] != op_b[WIDTH-1]) &&
                        (subDiff[WIDTH-1] != effA[WIDTH-1]);
              end
              ALU_MUL: state_d = MUL;
              ALU_CONV: begin
                state_d   = CONV;
                convA_d   = effA;
                convB_d   = op_b;
                convAcc_d = '0;
                lane_d    = '0;
              end
              ALU_NOP: ;
              default: illegal_d = 1'b1;
            endcase
          end
        end
        MUL: begin
          if (mulDone) begin
            state_d = IDLE;
            wrEn    = 1'b1;
            wrRes   = mulProduct;
          end
        end
        CONV: begin
          convAcc_d = convSum;
          convA_d   = convA_q >> 8;
          convB_d   = convB_q >> 8;
          if (lane_q == LANE_W'(LANES - 1)) begin
            state_d = IDLE;
            lane_d  = '0;
            wrEn    = 1'b1;
            wrRes   = WIDTH'(convSum);
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (wrEn) begin
      result_d         = wrRes;
      flags_d[FLAG_N]  = wrRes[WIDTH-1];
      flags_d[FLAG_Z]  = (wrRes == '0);
      flags_d[FLAG_C]  = wrC;
      flags_d[FLAG_V]  = wrV;
      outValid_d       = 1'b1;
    end
  end

  // State and output registers; an asynchronous reset aborts any operation
  // and returns every visible output to its idle value immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      result_q   <= '0;
      flags_q    <= '0;
      outValid_q <= 1'b0;
      illegal_q  <= 1'b0;
      convA_q    <= '0;
      convB_q    <= '0;
      convAcc_q  <= '0;
      lane_q     <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      outValid_q <= outValid_d;
      illegal_q  <= illegal_d;
      convA_q    <= convA_d;
      convB_q    <= convB_d;
      convAcc_q  <= convAcc_d;
      lane_q     <= lane_d;
    end
  end

  assign out_valid  = outValid_q;
  assign result     = result_q;
  assign flags      = flags_q;
  assign illegal_op = illegal_q;

endmodule
